// File: rtl/light_receiver.sv
// Optical line receiver: deserialises start/payload/stop frames from a
// photodetector level, sampling mid-bit and flagging bad stop bits.
`ifndef FRAME_SIZE
`define FRAME_SIZE 15
`endif

module light_receiver #(
  parameter int BIT_PERIOD = 16,
  parameter int FRAME_BITS = `FRAME_SIZE
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  signal,
  output logic [FRAME_BITS-1:0] data_out,
  output logic                  irq_rx,
  output logic                  frame_error,
  output logic                  busy
);

  localparam int CYC_W = $clog2(BIT_PERIOD);
  localparam int IDX_W = $clog2(FRAME_BITS);
  localparam logic [CYC_W-1:0] CYC_HALF = CYC_W'(BIT_PERIOD / 2 - 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                  state;
  logic [CYC_W-1:0]        cyc;
  logic [IDX_W-1:0]        idx;
  logic [FRAME_BITS-1:0]   shreg;
  logic                    sync1, s, s_d;
  logic [2:0]              warm;

  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cyc         <= '0;
      idx         <= '0;
      shreg       <= '0;
      data_out    <= '0;
      irq_rx      <= 1'b0;
      frame_error <= 1'b0;
      sync1       <= 1'b0;
      s           <= 1'b0;
      s_d         <= 1'b0;
      warm        <= '0;
    end else begin
      sync1       <= signal;
      s           <= sync1;
      s_d         <= s;
      // Edge detection waits until s and s_d both hold real line samples,
      // so a line already high at reset release is not seen as a rising edge.
      warm        <= {warm[1:0], 1'b1};
      irq_rx      <= 1'b0;
      frame_error <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        cyc   <= '0;
        idx   <= '0;
      end else begin
        case (state)
          IDLE: begin
            cyc <= '0;
            idx <= '0;
            if (warm[2] && s && !s_d) state <= START;
          end
          START: begin
            if (cyc == CYC_HALF) begin
              cyc   <= '0;
              idx   <= '0;
              state <= s ? DATA : IDLE;
            end else begin
              cyc <= cyc + 1'b1;
            end
          end
          DATA: begin
            if (cyc == CYC_LAST) begin
              cyc   <= '0;
              shreg <= {shreg[FRAME_BITS-2:0], s};
              if (idx == IDX_LAST) state <= STOP;
              else                 idx   <= idx + 1'b1;
            end else begin
              cyc <= cyc + 1'b1;
            end
          end
          STOP: begin
            if (cyc == CYC_LAST) begin
              cyc   <= '0;
              state <= IDLE;
              if (s) begin
                frame_error <= 1'b1;
              end else begin
                data_out <= shreg;
                irq_rx   <= 1'b1;
              end
            end else begin
              cyc <= cyc + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_light_receiver.sv
// Scoreboard bench for light_receiver: stimulus pushes expected pulses,
// an independent monitor pops and compares whenever irq_rx/frame_error fire.
module tb_light_receiver;

  localparam int BP = 16;
  localparam int FB = 15;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic          signal = 1'b0;
  logic [FB-1:0] data_out;
  logic          irq_rx, frame_error, busy;

  typedef struct {
    bit            err;
    logic [FB-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   irq_cyc_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cycle = 0;

  light_receiver #(.BIT_PERIOD(BP), .FRAME_BITS(FB)) dut (
    .clock(clock), .reset(reset), .enable(enable), .signal(signal),
    .data_out(data_out), .irq_rx(irq_rx), .frame_error(frame_error), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive_level(input logic lvl, input int n);
    signal = lvl;
    repeat (n) @(negedge clock);
  endtask

  task automatic send_frame(input logic [FB-1:0] d, input logic stop_lvl);
    drive_level(1'b1, BP);
    for (int i = FB - 1; i >= 0; i--) drive_level(d[i], BP);
    drive_level(stop_lvl, BP);
  endtask

  task automatic push_exp(input bit err, input logic [FB-1:0] d);
    exp_t e;
    e.err  = err;
    e.data = d;
    sb_q.push_back(e);
  endtask

  // Monitor: every pulse must match the head of the scoreboard; data_out
  // may only move together with irq_rx (or under reset).
  initial begin
    logic [FB-1:0] prev_data;
    exp_t e;
    prev_data = '0;
    forever begin
      @(posedge clock);
      #1;
      cycle++;
      if (reset !== 1'b1) begin
        if (irq_rx === 1'b1 || frame_error === 1'b1) begin
          vectors++;
          if (irq_rx === 1'b1) irq_cyc_q.push_back(cycle);
          if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_pulse: irq_rx=%b frame_error=%b data_out=%h, none expected",
                     irq_rx, frame_error, data_out);
          end else begin
            e = sb_q.pop_front();
            if (irq_rx !== !e.err || frame_error !== e.err || data_out !== e.data) begin
              miscompares++;
              $display("FAIL pulse: got irq_rx=%b frame_error=%b data_out=%h expected irq_rx=%b frame_error=%b data_out=%h",
                       irq_rx, frame_error, data_out, !e.err, e.err, e.data);
            end
          end
        end else if (data_out !== prev_data) begin
          vectors++;
          miscompares++;
          $display("FAIL data_out_hold: got %h expected %h (no irq_rx)", data_out, prev_data);
        end
      end
      prev_data = data_out;
    end
  end

  initial begin
    bit seen_busy;
    int n0;
    repeat (4) @(negedge clock);
    reset = 1'b0;

    // Reset state
    check("reset_data_out", 32'(data_out), 32'h0);
    check("reset_irq_rx", 32'(irq_rx), 32'h0);
    check("reset_frame_error", 32'(frame_error), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    drive_level(1'b0, 10);

    // Good frame
    push_exp(1'b0, 15'h2A5C);
    send_frame(15'h2A5C, 1'b0);
    drive_level(1'b0, 20);
    check("good_busy_after_stop", 32'(busy), 32'h0);
    check("good_data_out", 32'(data_out), 32'h2A5C);

    // 3-cycle glitch
    seen_busy = 1'b0;
    signal = 1'b1;
    repeat (3) begin @(negedge clock); if (busy) seen_busy = 1'b1; end
    signal = 1'b0;
    repeat (17) begin @(negedge clock); if (busy) seen_busy = 1'b1; end
    check("glitch_busy_seen", 32'(seen_busy), 32'h1);
    check("glitch_busy_after", 32'(busy), 32'h0);
    drive_level(1'b0, 10);

    // Bad stop bit: frame_error, data_out unchanged
    push_exp(1'b1, 15'h2A5C);
    send_frame(15'h1234, 1'b1);
    drive_level(1'b0, 32);
    check("bad_stop_data_out", 32'(data_out), 32'h2A5C);

    // Reset at payload bit 7, then a full frame
    begin
      logic [FB-1:0] pat;
      pat = 15'h5555;
      drive_level(1'b1, BP);
      for (int i = FB - 1; i > 7; i--) drive_level(pat[i], BP);
      drive_level(pat[7], BP / 2);
    end
    check("pre_reset_busy", 32'(busy), 32'h1);
    reset  = 1'b1;
    signal = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    drive_level(1'b0, 20);
    check("midreset_data_out", 32'(data_out), 32'h0);
    check("midreset_busy", 32'(busy), 32'h0);
    push_exp(1'b0, 15'h7FFF);
    send_frame(15'h7FFF, 1'b0);
    drive_level(1'b0, 20);
    check("after_reset_frame", 32'(data_out), 32'h7FFF);

    // Back-to-back frames
    n0 = irq_cyc_q.size();
    push_exp(1'b0, 15'h0001);
    push_exp(1'b0, 15'h4000);
    send_frame(15'h0001, 1'b0);
    send_frame(15'h4000, 1'b0);
    drive_level(1'b0, 20);
    check("b2b_irq_count", 32'(irq_cyc_q.size() - n0), 32'd2);
    if (irq_cyc_q.size() >= n0 + 2)
      check("b2b_spacing", 32'(irq_cyc_q[n0+1] - irq_cyc_q[n0]), 32'(17 * BP));
    check("b2b_data_out", 32'(data_out), 32'h4000);

    // Line already high across reset release
    drive_level(1'b1, 5);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    drive_level(1'b1, 40);
    check("high_after_reset_busy", 32'(busy), 32'h0);
    drive_level(1'b0, 20);

    // Enable dropped for one cycle at payload bit 3 (line held high)
    drive_level(1'b1, BP + 3 * BP + BP / 2);
    enable = 1'b0;
    @(negedge clock);
    enable = 1'b1;
    check("enable_drop_busy", 32'(busy), 32'h0);
    drive_level(1'b1, BP / 2 - 1 + 11 * BP);
    check("enable_drop_no_retrigger", 32'(busy), 32'h0);
    drive_level(1'b0, BP + 30);
    push_exp(1'b0, 15'h0F0F);
    send_frame(15'h0F0F, 1'b0);
    drive_level(1'b0, 20);
    check("after_enable_frame", 32'(data_out), 32'h0F0F);

    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/light_receiver.md
LIGHT_RECEIVER -- requirements
Module: light_receiver

Interface
REQ-001 SHALL have parameter BIT_PERIOD, default 16, clock cycles per line bit (even, >= 4).
REQ-002 SHALL have parameter FRAME_BITS, default `FRAME_SIZE (15), payload bits per frame.
REQ-003 SHALL have port clock  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  receive enable; low forces IDLE (suppresses self-reception while own LED drives).
REQ-006 SHALL have port signal  input  1  asynchronous photodetector level; 1 = light.
REQ-007 SHALL have port data_out  output  FRAME_BITS  last correctly framed payload.
REQ-008 SHALL have port irq_rx  output  1  one-cycle pulse: new data_out valid.
REQ-009 SHALL have port frame_error  output  1  one-cycle pulse: frame discarded (bad stop bit).
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-011 Line format SHALL be: idle low; start bit high for 1 bit period; FRAME_BITS payload bits, MSB first; stop bit low for 1 bit period.
REQ-012 signal SHALL pass a 2-flop synchronizer; all decisions use the synchronized value s; the previous value of s is s_d.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP; a counter cyc (0..BIT_PERIOD-1) and a bit index idx (0..FRAME_BITS-1) SHALL be used.
REQ-014 IDLE: when enable=1, s=1 and s_d=0 (rising edge), go to START with cyc=0; a line that stays high never retriggers.
REQ-015 START: at cyc=BIT_PERIOD/2-1, if s=1 go to DATA with cyc=0 and idx=0, else return to IDLE silently (glitch reject, no pulse).
REQ-016 DATA: at cyc=BIT_PERIOD-1, shift s into the shift register LSB, reset cyc; after the FRAME_BITS-th sample go to STOP with cyc=0.
REQ-017 Each bit SHALL therefore be sampled mid-bit: payload bit k at edge-detect cycle + BIT_PERIOD/2 + (k+1)*BIT_PERIOD.
REQ-018 STOP: at cyc=BIT_PERIOD-1, if s=0 load data_out from the shift register and pulse irq_rx; if s=1 pulse frame_error and leave data_out unchanged; go to IDLE in both cases.
REQ-019 irq_rx and frame_error SHALL be registered, high for exactly one cycle, and never high together.
REQ-020 data_out SHALL change only in the cycle irq_rx goes high, and SHALL hold its value until the next good frame.
REQ-021 From IDLE, a rising edge SHALL be accepted on the cycle immediately after STOP completes (back-to-back frames with no idle gap are legal).
REQ-022 enable=0 in any state SHALL force IDLE on the next edge, discard the partial frame, and assert no pulse; data_out is retained.
REQ-023 Counters SHALL be sized clog2 of their range and SHALL never wrap during a valid frame.

Reset
REQ-024 reset=1 SHALL set state IDLE, cyc=0, idx=0, shift register=0, data_out=0, irq_rx=0, frame_error=0, busy=0, and synchronizer flops=0, overriding all other inputs including mid-frame.
REQ-025 After reset deassertion, a line already high SHALL NOT start a frame until a low-to-high transition is seen.

Verification (BIT_PERIOD=16, FRAME_BITS=15)
REQ-026 Good frame 15'h2A5C with enable=1 -> exactly one irq_rx pulse, data_out=15'h2A5C, frame_error stays 0, busy low after STOP.
REQ-027 A 3-cycle high glitch on an idle line -> busy pulses briefly, returns to IDLE, no irq_rx and no frame_error.
REQ-028 Frame 15'h1234 with stop bit driven high -> one frame_error pulse, no irq_rx, data_out keeps its previous value.
REQ-029 Reset asserted at payload bit 7, line then idle; next frame 15'h7FFF -> data_out=0 until that frame completes, then 15'h7FFF with a single irq_rx.
REQ-030 Two back-to-back frames 15'h0001 and 15'h4000 with no gap -> two irq_rx pulses exactly 17*16 cycles apart, data_out sequence 15'h0001 then 15'h4000.
REQ-031 enable dropped at payload bit 3 for 1 cycle, frame continues -> no pulse for that frame; line high at re-enable does not trigger; next clean frame is received normally.
